// File: rtl/nios_pio_pkg.sv
// Shared constants for the Nios edge-capturing input PIO.
//   ADDR_*  : register offsets on the 2-bit Avalon address
//   MODE_*  : edge-capture mode encodings held in the MODE register
//   edge_hit: decides whether one bit's level transition is captured
package nios_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_MODE    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_ANY  = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    // cur is this cycle's debounced level, prev the level one cycle earlier.
    function automatic logic edge_hit(input logic [1:0] mode,
                                      input logic       cur,
                                      input logic       prev);
        logic hit;
        case (mode)
            MODE_RISE: hit = cur & ~prev;
            MODE_FALL: hit = ~cur & prev;
            MODE_ANY:  hit = cur ^ prev;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/nios_pio_in_edge_debounce.sv
// Per-pin input conditioning: 2-flop synchroniser followed by an optional
// stability counter.
//   clk, reset : system clock, synchronous active-high reset
//   din        : raw asynchronous pin
//   stable     : accepted (debounced) level
// With DEBOUNCE_CYCLES == 0 the synchroniser output is the accepted level.
// Otherwise a new level is accepted only after it has differed from the
// accepted level for DEBOUNCE_CYCLES consecutive cycles.
module pio_debounce #(
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic stable
);

    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (reset) sync <= 2'b00;
        else       sync <= {sync[0], din};
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign stable = sync[1];
        end else begin : g_count
            logic [CNT_W-1:0] cnt;
            logic             level;

            // cnt counts cycles the synchronised level has disagreed with the
            // accepted level; any agreement (a bounce back) restarts it.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt   <= '0;
                    level <= 1'b0;
                end else if (sync[1] == level) begin
                    cnt <= '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign stable = level;
        end
    endgenerate

endmodule

// File: rtl/nios_pio_in_edge.sv
// Avalon-MM input PIO with debounce, edge capture and masked level IRQ.
//   clk, reset  : system clock, synchronous active-high reset
//   address     : 0 DATA (RO), 1 MODE (RW [1:0]), 2 IRQMASK (RW), 3 EDGECAP (W1C)
//   chipselect, write_n, writedata : zero-wait-state write port
//   readdata    : registered read data, one cycle behind address
//   in_port     : asynchronous input pins
//   irq         : |(EDGECAP & IRQMASK)
module nios_pio_in_edge
    import nios_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [1:0]       mode;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] hits;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_mux;
    logic             wr;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_pin
            pio_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_db (
                .clk   (clk),
                .reset (reset),
                .din   (in_port[i]),
                .stable(stable[i])
            );
        end
    endgenerate

    assign wr  = chipselect & ~write_n;
    assign clr = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        hits = '0;
        for (int i = 0; i < WIDTH; i++)
            hits[i] = edge_hit(mode, stable[i], stable_d[i]);
    end

    // Unimplemented bits read back as zero.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
            ADDR_MODE:    rd_mux[1:0]       = mode;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
            default:      rd_mux[WIDTH-1:0] = edgecap;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d <= '0;
            mode     <= MODE_RISE;
            irqmask  <= '0;
            edgecap  <= '0;
            readdata <= '0;
        end else begin
            stable_d <= stable;
            if (wr && address == ADDR_MODE)    mode    <= writedata[1:0];
            if (wr && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
            // A capture in the same cycle as a clear of that bit must not be lost.
            edgecap  <= (edgecap & ~clr) | hits;
            readdata <= rd_mux;
        end
    end

    assign irq = |(edgecap & irqmask);

    // Upper writedata bits only matter for wide configurations.
    logic unused_wd;
    assign unused_wd = &{1'b0, writedata};

endmodule
